// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES-128/192/256 core, one round per clock, round keys fetched by index; AES_INV_EN adds decryption.
// Accept-to-valid NR+1 cycles; o_ready only while idle, o_valid/o_block held until i_ready.
module aes_round_engine #(
  parameter int KEY_BITS = 128
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_decrypt,
  input  logic [127:0] i_block,
  output logic [3:0]   o_rk_idx,
  input  logic [127:0] i_rk,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_block,
  output logic         o_busy
);

  localparam int         NR   = KEY_BITS / 32 + 6;
  localparam logic [3:0] NR_W = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_round_engine: KEY_BITS must be 128, 192 or 256");
  end

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_HOLD} fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         mode_q, mode_d;
  logic         dec_in;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
    return r;
  endfunction

  // Byte i of the block is row i%4, column i/4; row w rotates left by w columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(w+4*c) -: 8] = s[127-8*(w+4*((c+w)%4)) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a [4];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++)
        a[w] = s[127-8*(w+4*c) -: 8];
      for (int w = 0; w < 4; w++)
        r[127-8*(w+4*c) -: 8] = xtime(a[w]) ^ xtime(a[(w+1)%4]) ^ a[(w+1)%4]
                                ^ a[(w+2)%4] ^ a[(w+3)%4];
    end
    return r;
  endfunction

  logic [127:0] enc_sr, enc_mc;
  assign enc_sr = shift_rows(sub_bytes(state_q));
  assign enc_mc = mix_columns(enc_sr);

`ifdef AES_INV_EN
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Multiply by a 4-bit GF(2^8) constant (0x09/0x0b/0x0d/0x0e).
  function automatic logic [7:0] gmul4(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(w+4*c) -: 8] = s[127-8*(w+4*((c+4-w)%4)) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a [4];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++)
        a[w] = s[127-8*(w+4*c) -: 8];
      for (int w = 0; w < 4; w++)
        r[127-8*(w+4*c) -: 8] = gmul4(a[w], 4'he) ^ gmul4(a[(w+1)%4], 4'hb)
                                ^ gmul4(a[(w+2)%4], 4'hd) ^ gmul4(a[(w+3)%4], 4'h9);
    end
    return r;
  endfunction

  logic [127:0] dec_ark, dec_imc;
  assign dec_ark = inv_sub_bytes(inv_shift_rows(state_q)) ^ i_rk;
  assign dec_imc = inv_mix_columns(dec_ark);
  assign dec_in  = i_decrypt;
`else
  // Encrypt-only build: the mode input and register are tied off.
  logic unused_mode;
  assign unused_mode = i_decrypt ^ mode_q;
  assign dec_in      = 1'b0;
`endif

  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    rnd_d    = rnd_q;
    mode_d   = mode_q;
    o_rk_idx = rnd_q;
    o_ready  = 1'b0;
    o_valid  = 1'b0;
    o_busy   = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        o_ready  = 1'b1;
        o_rk_idx = dec_in ? NR_W : 4'd0;
        if (i_valid) begin
          fsm_d   = S_ROUND;
          state_d = i_block ^ i_rk;
          mode_d  = dec_in;
          rnd_d   = dec_in ? NR_W - 4'd1 : 4'd1;
        end
      end
      S_ROUND: begin
        o_busy = 1'b1;
`ifdef AES_INV_EN
        if (mode_q) begin
          if (rnd_q == 4'd0) begin
            state_d = dec_ark;
            fsm_d   = S_HOLD;
          end else begin
            state_d = dec_imc;
            rnd_d   = rnd_q - 4'd1;
          end
        end else
`endif
        begin
          // Last round skips MixColumns; the terminal compare keeps rnd from wrapping.
          if (rnd_q == NR_W) begin
            state_d = enc_sr ^ i_rk;
            fsm_d   = S_HOLD;
          end else begin
            state_d = enc_mc ^ i_rk;
            rnd_d   = rnd_q + 4'd1;
          end
        end
      end
      S_HOLD: begin
        o_valid = 1'b1;
        o_busy  = 1'b1;
        if (i_ready) fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      rnd_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
      mode_q  <= mode_d;
    end
  end

  assign o_block = state_q;

endmodule

// File: tb/tb_aes_round_engine.sv
// Bench for aes_round_engine: three instances (AES-128/192/256) fed by a key-schedule table,
// checked against a byte-level AES model built from GF(2^8) arithmetic.
module tb_aes_round_engine;

`ifdef AES_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk;
  logic         rst;
  logic [127:0] blk_in;
  logic         dec_in;
  logic         vld     [3];
  logic         rdy     [3];
  logic         ordy    [3];
  logic         oval    [3];
  logic         obusy   [3];
  logic [3:0]   rk_idx  [3];
  logic [127:0] blk_out [3];
  logic [127:0] rks     [3][16];
  logic [7:0]   sbox    [256];
  logic [7:0]   isbox   [256];

  int checks_total  = 0;
  int checks_passed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_round_engine #(.KEY_BITS(128 + 64*g)) u_dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_valid   (vld[g]),
      .o_ready   (ordy[g]),
      .i_decrypt (dec_in),
      .i_block   (blk_in),
      .o_rk_idx  (rk_idx[g]),
      .i_rk      (rks[g][rk_idx[g]]),
      .o_valid   (oval[g]),
      .i_ready   (rdy[g]),
      .o_block   (blk_out[g]),
      .o_busy    (obusy[g])
    );
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    logic [15:0] d;
    d = {v, v} << k;
    return d[15:8];
  endfunction

  // S-box = affine map of the multiplicative inverse, found by exhaustive search.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = 8'h63;
      for (int k = 0; k < 5; k++) s ^= rotl8(inv, k);
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  task automatic expand_key(input int sel, input logic [255:0] key);
    int nk, nr;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    nk = 4 + 2*sel;
    nr = nk + 6;
    rcon = 8'h01;
    for (int i = 0; i < 4*(nr+1); i++) begin
      if (i < nk) w[i] = key[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
          rcon = gmul(rcon, 8'h02);
        end else if (nk > 6 && i % nk == 4) t = subword(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r < 16; r++)
      if (r <= nr) rks[sel][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else rks[sel][r] = '0;
  endtask

  function automatic logic [127:0] m_sub(input logic [127:0] v, input bit inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = inv ? isbox[v[127-8*i -: 8]] : sbox[v[127-8*i -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] m_shift(input logic [127:0] v, input bit inv);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(w+4*c) -: 8] = v[127-8*(w+4*((c + (inv ? 4-w : w)) % 4)) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] m_mix(input logic [127:0] v, input bit inv);
    logic [127:0] r;
    logic [7:0] cf [4];
    logic [7:0] acc;
    if (inv) begin cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09; end
    else     begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc ^= gmul(cf[j], v[127-8*((w+j)%4 + 4*c) -: 8]);
        r[127-8*(w+4*c) -: 8] = acc;
      end
    return r;
  endfunction

  function automatic logic [127:0] aes_model(input int sel, input bit dec, input logic [127:0] blk);
    int nr;
    logic [127:0] v;
    nr = 10 + 2*sel;
    if (!dec) begin
      v = blk ^ rks[sel][0];
      for (int r = 1; r <= nr; r++) begin
        v = m_shift(m_sub(v, 1'b0), 1'b0);
        if (r < nr) v = m_mix(v, 1'b0);
        v ^= rks[sel][r];
      end
    end else begin
      v = blk ^ rks[sel][nr];
      for (int r = nr - 1; r >= 0; r--) begin
        v = m_sub(m_shift(v, 1'b1), 1'b1) ^ rks[sel][r];
        if (r > 0) v = m_mix(v, 1'b1);
      end
    end
    return v;
  endfunction

  // ---------------- transaction driver ----------------
  // lat = cycle index (accept edge = cycle 0) at which o_valid is seen; rk_err counts
  // wrong round-key indices or a missing o_ready at the accept cycle.
  task automatic run_txn(input int sel, input bit dec, input logic [127:0] blk,
                         output logic [127:0] res, output int lat, output int rk_err);
    int nr, cyc;
    bit eff;
    nr = 10 + 2*sel;
    eff = dec & INV_EN;
    rk_err = 0;
    res = '0;
    lat = -1;
    @(negedge clk);
    blk_in = blk; dec_in = dec; vld[sel] = 1'b1; rdy[sel] = 1'b1;
    #1;
    if (ordy[sel] !== 1'b1) rk_err++;
    if (rk_idx[sel] !== (eff ? 4'(nr) : 4'd0)) rk_err++;
    @(posedge clk);
    @(negedge clk);
    vld[sel] = 1'b0; blk_in = ~blk; dec_in = ~dec;
    cyc = 0;
    while (oval[sel] !== 1'b1 && cyc < 40) begin
      if (rk_idx[sel] !== (eff ? 4'(nr - 1 - cyc) : 4'(cyc + 1))) rk_err++;
      @(negedge clk);
      cyc++;
    end
    if (oval[sel] === 1'b1) begin
      lat = cyc + 1;
      res = blk_out[sel];
    end
    @(negedge clk);
    rdy[sel] = 1'b0;
  endtask

  typedef struct {
    string        name;
    int           sel;
    bit           dec;
    logic [127:0] blk;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [5];
  logic [127:0] res, held, b2, exp;
  logic [255:0] key;
  int lat, rkerr, cyc, bad, seen, sel;
  bit dec;

  initial begin
    rst = 1'b1; blk_in = '0; dec_in = 1'b0;
    for (int i = 0; i < 3; i++) begin vld[i] = 1'b0; rdy[i] = 1'b0; end
    build_sbox();
    for (int i = 0; i < 32; i++) key[255-8*i -: 8] = 8'(i);
    for (int s = 0; s < 3; s++) expand_key(s, key);

    vecs[0] = '{"fips128_enc", 0, 1'b0, PT, CT128};
    vecs[1] = '{"fips192_enc", 1, 1'b0, PT, CT192};
    vecs[2] = '{"fips256_enc", 2, 1'b0, PT, CT256};
    vecs[3] = '{"fips128_dec", 0, 1'b1, CT128, INV_EN ? PT : aes_model(0, 1'b0, CT128)};
    vecs[4] = '{"dec_flag_on_pt", 0, 1'b1, PT, INV_EN ? aes_model(0, 1'b1, PT) : CT128};

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("reset_ready[%0d]", s), ordy[s], 1);
      check($sformatf("reset_valid[%0d]", s), oval[s], 0);
      check($sformatf("reset_busy[%0d]", s), obusy[s], 0);
      check($sformatf("reset_block[%0d]", s), blk_out[s], 0);
    end
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i].sel, vecs[i].dec, vecs[i].blk, res, lat, rkerr);
      check({vecs[i].name, " result"}, res, vecs[i].exp);
      check({vecs[i].name, " latency"}, lat, 11 + 2*vecs[i].sel);
      check({vecs[i].name, " rk_idx"}, rkerr, 0);
    end

    // Backpressure: result held 20 cycles while a second block is offered and must wait.
    b2 = 128'h0123456789abcdeffedcba9876543210;
    @(negedge clk);
    blk_in = PT; dec_in = 1'b0; vld[0] = 1'b1; rdy[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0; blk_in = '1;
    cyc = 0;
    while (oval[0] !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    check("bp_valid", oval[0], 1);
    held = blk_out[0];
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 5) begin blk_in = b2; vld[0] = 1'b1; end
      if (blk_out[0] !== held || ordy[0] !== 1'b0 || oval[0] !== 1'b1 || obusy[0] !== 1'b1) bad++;
      @(negedge clk);
    end
    check("bp_held_block", held, CT128);
    check("bp_stable", bad, 0);
    rdy[0] = 1'b1;
    @(negedge clk);
    check("bp_ready_next", ordy[0], 1);
    check("bp_valid_drop", oval[0], 0);
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0; blk_in = '0;
    check("bp_second_busy", obusy[0], 1);
    cyc = 0;
    while (oval[0] !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    check("bp_second_result", blk_out[0], aes_model(0, 1'b0, b2));
    @(negedge clk);
    rdy[0] = 1'b0;

    // Reset in cycle 5 of a transaction discards the block.
    @(negedge clk);
    blk_in = PT; dec_in = 1'b0; vld[0] = 1'b1; rdy[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy", obusy[0], 0);
    check("rst_valid", oval[0], 0);
    check("rst_block", blk_out[0], 0);
    check("rst_ready", ordy[0], 1);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (oval[0] !== 1'b0) seen++;
    end
    check("rst_no_result", seen, 0);
    rdy[0] = 1'b0;

    // Random keys, blocks, modes and key sizes.
    for (int n = 0; n < 24; n++) begin
      sel = $urandom_range(0, 2);
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      expand_key(sel, key);
      dec = 1'($urandom_range(0, 1));
      b2  = {$urandom, $urandom, $urandom, $urandom};
      exp = aes_model(sel, dec & INV_EN, b2);
      run_txn(sel, dec, b2, res, lat, rkerr);
      check($sformatf("rand%0d_result", n), res, exp);
      check($sformatf("rand%0d_latency_rk", n), (rkerr == 0) ? lat : -2, 11 + 2*sel);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
